// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: self-timed row-scan driver for a multi-colour LED matrix,
// with a double-buffered frame bitmap and inter-row blanking.
// Latency: all outputs are registered. A LOAD is first shown after the next frame boundary.
// Backpressure: none. LOAD is accepted on any cycle, and the last write before a swap wins.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset. Reset blanks the outputs immediately.
//   enable      - scan enable. While it is low the display is dark and held at row 0.
//   load, frame - strobe and bitmap. Bit index = c*ROWS*COLS + k*ROWS + r.
//   bright      - 3-bit brightness. It is used only when LED_DIM_EN is defined.
//   row_n       - active-low row sinks. At most one bit is low at a time.
//   col         - active-high column sources. Index = c*COLS + k.
//   row_idx     - the row currently being scanned.
//   frame_done  - one-cycle pulse after the last DRIVE cycle of the last row.
// Optional feature macro: LED_DIM_EN (PWM dimming of the columns within each DRIVE phase).
module led_matrix_scanner #(
  parameter int ROWS      = 8,
  parameter int COLS      = 4,
  parameter int COLORS    = 2,
  parameter int DWELL_CYC = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [ROWS*COLS*COLORS-1:0]   frame,
  input  logic [2:0]                    bright,
  output logic [ROWS-1:0]               row_n,
  output logic [COLS*COLORS-1:0]        col,
  output logic [$clog2(ROWS)-1:0]       row_idx,
  output logic                          frame_done
);

  localparam int RW   = $clog2(ROWS);
  localparam int NB   = ROWS * COLS * COLORS;
  localparam int NC   = COLS * COLORS;
  localparam int CMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   row_nxt;
  logic            wrap;
  logic            swap;
  logic            halted;
  logic [NB-1:0]   display, display_nxt;
  logic [NB-1:0]   pending;
  logic            pend_flag, pend_flag_nxt;
  logic [ROWS-1:0] row_sel;
  logic [NC-1:0]   col_map;
  logic [ROWS-1:0] row_n_nxt;
  logic [NC-1:0]   col_nxt;
  logic            lit;

  // Scan sequencer: BLANK (BLANK_CYC clocks), then DRIVE (DWELL_CYC clocks), once per row.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row_idx;
    wrap      = 1'b0;
    if (!enable) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      row_nxt   = '0;
    end else if (state == BLANK) begin
      if (BLANK_CYC == 0 || cnt == BLANK_LAST) begin
        state_nxt = DRIVE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == DWELL_LAST) begin
        cnt_nxt   = '0;
        state_nxt = (BLANK_CYC == 0) ? DRIVE : BLANK;
        if (row_idx == ROW_LAST) begin
          row_nxt = '0;
          wrap    = 1'b1;
        end else begin
          row_nxt = row_idx + 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // The first enabled edge after a dark period counts as a frame boundary, so a frame
  // loaded while the display was disabled appears as soon as scanning resumes.
  assign swap          = wrap | (enable & halted);
  assign display_nxt   = (swap && pend_flag) ? pending : display;
  // A LOAD on the swap edge keeps the flag set. The swap consumes the older contents.
  assign pend_flag_nxt = load | (pend_flag & ~swap);

`ifdef LED_DIM_EN
  localparam int STEP = DWELL_CYC / 8;
  logic [2:0] bright_q;
  logic [2:0] bright_use;

  // Brightness is latched in the first DRIVE cycle. The outputs are computed one cycle
  // ahead, so that cycle uses the live input and later cycles use the latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= '0;
    end else if (state == DRIVE && cnt == '0) begin
      bright_q <= bright;
    end
  end

  always_comb begin
    bright_use = (state == DRIVE && cnt == '0) ? bright : bright_q;
    lit        = int'(cnt_nxt) < STEP * (int'(bright_use) + 1);
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit           = 1'b1;
`endif

  // The outputs are computed from the next state, so the registered outputs line up
  // with the state that is current in the same cycle.
  always_comb begin
    row_sel          = '0;
    row_sel[row_nxt] = 1'b1;
    col_map          = '0;
    for (int i = 0; i < NC; i++) begin
      col_map[i] = |(display_nxt[i*ROWS +: ROWS] & row_sel);
    end
    row_n_nxt = '1;
    col_nxt   = '0;
    if (state_nxt == DRIVE) begin
      row_n_nxt = ~row_sel;
      if (lit) begin
        col_nxt = col_map;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      row_idx    <= '0;
      display    <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      halted     <= 1'b1;
      row_n      <= '1;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      row_idx    <= row_nxt;
      display    <= display_nxt;
      if (load) begin
        pending <= frame;
      end
      pend_flag  <= pend_flag_nxt;
      halted     <= ~enable;
      row_n      <= row_n_nxt;
      col        <= col_nxt;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner with default parameters.
// Time t counts clock edges after the first reset release. Expected outputs for
// each t are queued up front, and a negedge monitor pops and compares them.
module tb_led_matrix_scanner;

  localparam int T0 = 3;  // absolute edge count at which t = 0

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [63:0] frame = '0;
  logic [2:0]  bright = 3'd7;
  logic [7:0]  row_n;
  logic [7:0]  col;
  logic [2:0]  row_idx;
  logic        frame_done;

  int p = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         at;
    logic [7:0] rn;
    logic [7:0] cl;
    logic [2:0] ix;
    logic       fd;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  led_matrix_scanner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .frame      (frame),
    .bright     (bright),
    .row_n      (row_n),
    .col        (col),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) p <= p + 1;

  task automatic cmp(input string nm, input int t, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, req);
    end
  endtask

  // rc holds the expected col value for row r in byte r. With dim set, the columns are
  // lit only for the first 4 clocks of each 16-clock dwell (brightness 1).
  task automatic push_seg(input int t0, input int t1, input int base,
                          input logic [63:0] rc, input bit dim);
    for (int t = t0; t <= t1; t++) begin
      int   pos, ph, r, w;
      exp_t e;
      pos  = t - base;
      ph   = pos % 144;
      r    = ph / 18;
      w    = ph % 18;
      e.at = t + T0;
      e.rn = 8'hff;
      e.cl = 8'h00;
      e.ix = 3'(r);
      e.fd = (ph == 0 && pos > 0);
      if (w >= 2) begin
        e.rn = ~(8'h01 << r);
        e.cl = rc[r*8 +: 8];
        if (dim && (w - 2) >= 4) e.cl = 8'h00;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_dark(input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      exp_t e;
      e.at = t + T0;
      e.rn = 8'hff;
      e.cl = 8'h00;
      e.ix = 3'd0;
      e.fd = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic at_t(input int t);
    wait (p == t + T0);
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input int t, input logic [63:0] f);
    at_t(t);
    load  = 1'b1;
    frame = f;
    at_t(t + 1);
    load  = 1'b0;
  endtask

  // Monitor: compares each queued expectation at its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at < p) begin
      total++;
      bad++;
      $display("FAIL missed t=%0d actual=none required=check", q[0].at - T0);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].at == p) begin
      cur = q.pop_front();
      cmp("row_n",      cur.at - T0, row_n,                 cur.rn);
      cmp("col",        cur.at - T0, col,                   cur.cl);
      cmp("row_idx",    cur.at - T0, {5'd0, row_idx},       {5'd0, cur.ix});
      cmp("frame_done", cur.at - T0, {7'd0, frame_done},    {7'd0, cur.fd});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int t_end;
    // Frames: F1 = green k0 r0; O = orange k0 r0; A = green k1 r0 + orange k2 r7;
    // B = orange k3 r0 + green k2 r5; C = green k0 r1.
    push_seg(0,   143, 0, 64'h0, 0);
    push_seg(144, 287, 0, 64'h0000_0000_0000_0001, 0);
    push_seg(288, 431, 0, 64'h0000_0000_0000_0010, 0);
    push_seg(432, 575, 0, 64'h4000_0000_0000_0002, 0);
    push_seg(576, 672, 0, 64'h0000_0400_0000_0080, 0);
    push_dark(673, 679);
    push_seg(680, 845, 680, 64'h0000_0000_0000_0100, 0);
    push_seg(848, 1279, 848, 64'h0, 0);
`ifdef LED_DIM_EN
    push_seg(1280, 1423, 848, 64'hffff_ffff_ffff_ffff, 1);
    t_end = 1423;
`else
    t_end = 1279;
`endif

    at_t(0);
    rst_n = 1'b1;
    do_load(10,  64'h0000_0000_0000_0001);
    do_load(203, 64'h0000_0001_0000_0000);
    do_load(300, 64'h0080_0000_0000_0100);
    do_load(431, 64'h0100_0000_0020_0000);  // arrives on the swap edge
    at_t(672);
    enable = 1'b0;
    do_load(675, 64'h0000_0000_0000_0002);
    at_t(680);
    enable = 1'b1;
    do_load(830, 64'hffff_ffff_ffff_ffff);
    at_t(845);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async_row_n",   845, row_n,            8'hff);
    cmp("async_col",     845, col,              8'h00);
    cmp("async_row_idx", 845, {5'd0, row_idx},  8'h00);
    cmp("async_fd",      845, {7'd0, frame_done}, 8'h00);
    at_t(848);
    rst_n = 1'b1;
`ifdef LED_DIM_EN
    at_t(1140);
    bright = 3'd1;
    load   = 1'b1;
    frame  = '1;
    at_t(1141);
    load   = 1'b0;
`endif
    at_t(t_end);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
